// File: rtl/formula_task_dispatcher.sv
// Dispatches (a,b,c) triplets to a pool of iterative isqrt formula workers and
// returns their results strictly in acceptance order.

module formula_isqrt_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] x,
   output logic        done,
   output logic [15:0] root
);
   logic [31:0] op_q;
   logic [17:0] rem_q;
   logic [15:0] rt_q;
   logic [4:0]  cnt_q;
   logic        run_q;
   logic        done_q;
   logic [19:0] rem_sh;
   logic [19:0] trial;

   // Digit-by-digit square root, one result bit per cycle
   always_comb begin
      rem_sh = {rem_q, op_q[31:30]};
      trial  = {2'b00, rt_q, 2'b01};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q   <= '0;
         rem_q  <= '0;
         rt_q   <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            op_q  <= x;
            rem_q <= '0;
            rt_q  <= '0;
            cnt_q <= 5'd16;
            run_q <= 1'b1;
         end else if (run_q) begin
            op_q <= {op_q[29:0], 2'b00};
            if (rem_sh >= trial) begin
               rem_q <= 18'(rem_sh - trial);
               rt_q  <= {rt_q[14:0], 1'b1};
            end else begin
               rem_q <= rem_sh[17:0];
               rt_q  <= {rt_q[14:0], 1'b0};
            end
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               run_q  <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign done = done_q;
   assign root = rt_q;
endmodule

module formula_1_impl_1_top (
   input  logic        clk,
   input  logic        rst,
   input  logic        arg_vld,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] c,
   output logic        res_vld,
   output logic [31:0] res
);
   logic [15:0] ra, rb, rc;
   logic        da, db, dc;
   logic        vld_q;
   logic [31:0] res_q;

   formula_isqrt_seq u_sa (.clk(clk), .rst(rst), .start(arg_vld), .x(a), .done(da), .root(ra));
   formula_isqrt_seq u_sb (.clk(clk), .rst(rst), .start(arg_vld), .x(b), .done(db), .root(rb));
   formula_isqrt_seq u_sc (.clk(clk), .rst(rst), .start(arg_vld), .x(c), .done(dc), .root(rc));

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= 1'b0;
         res_q <= '0;
      end else begin
         vld_q <= da & db & dc;
         if (da & db & dc) res_q <= 32'(ra) + 32'(rb) + 32'(rc);
      end
   end

   assign res_vld = vld_q;
   assign res     = res_q;
endmodule

module formula_1_impl_2_top (
   input  logic        clk,
   input  logic        rst,
   input  logic        arg_vld,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] c,
   output logic        res_vld,
   output logic [31:0] res
);
   localparam logic [1:0] ST_IDLE = 2'd0, ST_A = 2'd1, ST_B = 2'd2, ST_C = 2'd3;

   logic [1:0]  st_q;
   logic [31:0] b_q, c_q, acc_q, res_q;
   logic        vld_q;
   logic        start, done;
   logic [31:0] x;
   logic [15:0] root;

   // One shared isqrt unit walks a, b, c in turn
   formula_isqrt_seq u_sq (.clk(clk), .rst(rst), .start(start), .x(x), .done(done), .root(root));

   always_comb begin
      start = 1'b0;
      x     = a;
      case (st_q)
         ST_IDLE: start = arg_vld;
         ST_A: begin
            start = done;
            x     = b_q;
         end
         ST_B: begin
            start = done;
            x     = c_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q  <= ST_IDLE;
         b_q   <= '0;
         c_q   <= '0;
         acc_q <= '0;
         res_q <= '0;
         vld_q <= 1'b0;
      end else begin
         vld_q <= 1'b0;
         case (st_q)
            ST_IDLE: if (arg_vld) begin
               b_q   <= b;
               c_q   <= c;
               acc_q <= '0;
               st_q  <= ST_A;
            end
            ST_A: if (done) begin
               acc_q <= acc_q + 32'(root);
               st_q  <= ST_B;
            end
            ST_B: if (done) begin
               acc_q <= acc_q + 32'(root);
               st_q  <= ST_C;
            end
            default: if (done) begin
               res_q <= acc_q + 32'(root);
               vld_q <= 1'b1;
               st_q  <= ST_IDLE;
            end
         endcase
      end
   end

   assign res_vld = vld_q;
   assign res     = res_q;
endmodule

module formula_2_top (
   input  logic        clk,
   input  logic        rst,
   input  logic        arg_vld,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] c,
   output logic        res_vld,
   output logic [31:0] res
);
   localparam logic [1:0] ST_IDLE = 2'd0, ST_C = 2'd1, ST_B = 2'd2, ST_A = 2'd3;

   logic [1:0]  st_q;
   logic [31:0] a_q, b_q, res_q;
   logic        vld_q;
   logic        start, done;
   logic [31:0] x;
   logic [15:0] root;

   // Nested chain: isqrt(c), then isqrt(b + r), then isqrt(a + r)
   formula_isqrt_seq u_sq (.clk(clk), .rst(rst), .start(start), .x(x), .done(done), .root(root));

   always_comb begin
      start = 1'b0;
      x     = c;
      case (st_q)
         ST_IDLE: start = arg_vld;
         ST_C: begin
            start = done;
            x     = b_q + 32'(root);
         end
         ST_B: begin
            start = done;
            x     = a_q + 32'(root);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q  <= ST_IDLE;
         a_q   <= '0;
         b_q   <= '0;
         res_q <= '0;
         vld_q <= 1'b0;
      end else begin
         vld_q <= 1'b0;
         case (st_q)
            ST_IDLE: if (arg_vld) begin
               a_q  <= a;
               b_q  <= b;
               st_q <= ST_C;
            end
            ST_C: if (done) st_q <= ST_B;
            ST_B: if (done) st_q <= ST_A;
            default: if (done) begin
               res_q <= 32'(root);
               vld_q <= 1'b1;
               st_q  <= ST_IDLE;
            end
         endcase
      end
   end

   assign res_vld = vld_q;
   assign res     = res_q;
endmodule

module formula_task_dispatcher #(
   parameter int unsigned formula    = 1,
   parameter int unsigned impl       = 1,
   parameter int unsigned N_CHANNELS = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              arg_vld,
   output logic                              arg_rdy,
   input  logic [31:0]                       a,
   input  logic [31:0]                       b,
   input  logic [31:0]                       c,
   output logic                              res_vld,
   input  logic                              res_rdy,
   output logic [31:0]                       res,
   output logic [$clog2(N_CHANNELS+1)-1:0]   busy_cnt,
   output logic                              err
);
   localparam int unsigned IW = $clog2(N_CHANNELS);
   localparam int unsigned CW = $clog2(N_CHANNELS + 1);
   localparam logic [1:0] CH_IDLE = 2'd0, CH_BUSY = 2'd1, CH_DONE = 2'd2;

   logic [1:0]            ch_st   [N_CHANNELS];
   logic [31:0]           ch_res  [N_CHANNELS];
   logic [31:0]           wrk_res [N_CHANNELS];
   logic [IW-1:0]         ord_q   [N_CHANNELS];
   logic [N_CHANNELS-1:0] wrk_go;
   logic [N_CHANNELS-1:0] wrk_vld;
   logic [31:0]           wa_q, wb_q, wc_q;
   logic [IW-1:0]         hd_q, tl_q;
   logic                  res_vld_q;
   logic [31:0]           res_q;
   logic [CW-1:0]         busy_q;
   logic                  err_q;

   logic [N_CHANNELS-1:0] idle;
   logic [IW-1:0]         sel, head;
   logic                  accept, emit;

   if (N_CHANNELS < 2 || !(formula == 2 || (formula == 1 && (impl == 1 || impl == 2))))
   begin : g_bad_cfg
      $error("formula_task_dispatcher: unsupported formula/impl/N_CHANNELS");
   end

   function automatic logic [IW-1:0] ptr_next(input logic [IW-1:0] p);
      return (p == IW'(N_CHANNELS - 1)) ? '0 : p + IW'(1);
   endfunction

   // Descending scan so the lowest free index is the one left in sel
   always_comb begin
      idle = '0;
      sel  = '0;
      for (int i = N_CHANNELS - 1; i >= 0; i--) begin
         if (ch_st[i] == CH_IDLE) begin
            idle[i] = 1'b1;
            sel     = IW'(i);
         end
      end
   end

   assign head    = ord_q[hd_q];
   assign arg_rdy = !rst && (|idle);
   assign accept  = arg_vld && arg_rdy;
   assign emit    = (busy_q != '0) && (ch_st[head] == CH_DONE) && (!res_vld_q || res_rdy);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_CHANNELS; i++) begin
            ch_st[i]  <= CH_IDLE;
            ch_res[i] <= '0;
            ord_q[i]  <= '0;
         end
         wrk_go    <= '0;
         wa_q      <= '0;
         wb_q      <= '0;
         wc_q      <= '0;
         hd_q      <= '0;
         tl_q      <= '0;
         res_vld_q <= 1'b0;
         res_q     <= '0;
         busy_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         wrk_go <= '0;
         for (int i = 0; i < N_CHANNELS; i++) begin
            if (wrk_vld[i]) begin
               if (ch_st[i] == CH_BUSY) begin
                  ch_st[i]  <= CH_DONE;
                  ch_res[i] <= wrk_res[i];
               end else begin
                  err_q <= 1'b1;
               end
            end
         end
         if (accept) begin
            ch_st[sel]  <= CH_BUSY;
            wrk_go[sel] <= 1'b1;
            wa_q        <= a;
            wb_q        <= b;
            wc_q        <= c;
            ord_q[tl_q] <= sel;
            tl_q        <= ptr_next(tl_q);
         end
         if (emit) begin
            ch_st[head] <= CH_IDLE;
            res_q       <= ch_res[head];
            res_vld_q   <= 1'b1;
            hd_q        <= ptr_next(hd_q);
         end else if (res_vld_q && res_rdy) begin
            res_vld_q <= 1'b0;
         end
         busy_q <= busy_q + CW'(accept) - CW'(emit);
      end
   end

   for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
      if (formula == 2) begin : g_f2
         formula_2_top u_wrk (
            .clk(clk), .rst(rst), .arg_vld(wrk_go[i]), .a(wa_q), .b(wb_q), .c(wc_q),
            .res_vld(wrk_vld[i]), .res(wrk_res[i])
         );
      end else if (impl == 2) begin : g_f1i2
         formula_1_impl_2_top u_wrk (
            .clk(clk), .rst(rst), .arg_vld(wrk_go[i]), .a(wa_q), .b(wb_q), .c(wc_q),
            .res_vld(wrk_vld[i]), .res(wrk_res[i])
         );
      end else begin : g_f1i1
         formula_1_impl_1_top u_wrk (
            .clk(clk), .rst(rst), .arg_vld(wrk_go[i]), .a(wa_q), .b(wb_q), .c(wc_q),
            .res_vld(wrk_vld[i]), .res(wrk_res[i])
         );
      end
   end

   assign res_vld  = res_vld_q;
   assign res      = res_q;
   assign busy_cnt = busy_q;
   assign err      = err_q;
endmodule

// File: tb/tb_formula_task_dispatcher.sv
// Directed bench for formula_task_dispatcher: three configurations exercised in turn
// from one linear stimulus sequence, with results checked against a local isqrt model.

module tb_formula_task_dispatcher;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic rst;
   // u1: formula 1 impl 1, 4 channels
   logic vld1, rdy1, rv1, rr1, err1;
   logic [31:0] a1, b1, c1, res1;
   logic [2:0]  bc1;
   // u2: formula 2, 60 channels
   logic vld2, rdy2, rv2, rr2, err2;
   logic [31:0] a2, b2, c2, res2;
   logic [5:0]  bc2;
   // u3: formula 1 impl 2, 2 channels
   logic vld3, rdy3, rv3, rr3, err3;
   logic [31:0] a3, b3, c3, res3;
   logic [1:0]  bc3;

   formula_task_dispatcher #(.formula(1), .impl(1), .N_CHANNELS(4)) u1 (
      .clk(clk), .rst(rst), .arg_vld(vld1), .arg_rdy(rdy1), .a(a1), .b(b1), .c(c1),
      .res_vld(rv1), .res_rdy(rr1), .res(res1), .busy_cnt(bc1), .err(err1)
   );
   formula_task_dispatcher #(.formula(2), .impl(1), .N_CHANNELS(60)) u2 (
      .clk(clk), .rst(rst), .arg_vld(vld2), .arg_rdy(rdy2), .a(a2), .b(b2), .c(c2),
      .res_vld(rv2), .res_rdy(rr2), .res(res2), .busy_cnt(bc2), .err(err2)
   );
   formula_task_dispatcher #(.formula(1), .impl(2), .N_CHANNELS(2)) u3 (
      .clk(clk), .rst(rst), .arg_vld(vld3), .arg_rdy(rdy3), .a(a3), .b(b3), .c(c3),
      .res_vld(rv3), .res_rdy(rr3), .res(res3), .busy_cnt(bc3), .err(err3)
   );

   logic [31:0] q1[$], q2[$], q3[$];
   int stall2 = 0;

   always @(negedge clk) begin
      if (rv1 && rr1) q1.push_back(res1);
      if (rv2 && rr2) q2.push_back(res2);
      if (rv3 && rr3) q3.push_back(res3);
      if (vld2 && !rdy2) stall2++;
   end

   function automatic logic [31:0] isq(input logic [31:0] x);
      logic [31:0] r;
      logic [31:0] t;
      r = '0;
      for (int k = 15; k >= 0; k--) begin
         t = r | (32'd1 << k);
         if (64'(t) * 64'(t) <= 64'(x)) r = t;
      end
      return r;
   endfunction

   function automatic logic [31:0] f2m(input logic [31:0] x, y, z);
      return isq(x + isq(y + isq(z)));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int qsize(input int u);
      case (u)
         1: return q1.size();
         2: return q2.size();
         default: return q3.size();
      endcase
   endfunction

   function automatic logic rdy_of(input int u);
      case (u)
         1: return rdy1;
         2: return rdy2;
         default: return rdy3;
      endcase
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic set_arg(input int u, input logic v, input logic [31:0] x, y, z);
      case (u)
         1: begin vld1 = v; a1 = x; b1 = y; c1 = z; end
         2: begin vld2 = v; a2 = x; b2 = y; c2 = z; end
         default: begin vld3 = v; a3 = x; b3 = y; c3 = z; end
      endcase
   endtask

   // Called just after a rising edge; returns just after the accepting edge
   task automatic send(input int u, input logic [31:0] x, y, z);
      int n;
      n = 0;
      set_arg(u, 1'b1, x, y, z);
      tick();
      while (!rdy_of(u) && n < 300) begin
         tick();
         n++;
      end
      if (!rdy_of(u)) begin
         total++;
         bad++;
         $error("FAIL send_timeout: observed=arg_rdy low expected=accept within 300 cycles");
      end
      @(posedge clk);
      #1;
      set_arg(u, 1'b0, x, y, z);
   endtask

   task automatic wait_n(input int u, input int n, input int budget, input string tag);
      int k;
      k = 0;
      while (qsize(u) < n && k < budget) begin
         tick();
         k++;
      end
      chk(tag, 32'(qsize(u)), 32'(n));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
      $fatal(1, "watchdog");
   end

   logic [31:0] ea[100], eb[100], ec[100];
   logic [31:0] e4[5];
   int unstable;

   initial begin
      rst = 1'b1;
      rr1 = 1'b1; rr2 = 1'b1; rr3 = 1'b1;
      set_arg(1, 1'b0, 0, 0, 0);
      set_arg(2, 1'b0, 0, 0, 0);
      set_arg(3, 1'b0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      tick();
      chk("rdy_in_reset", rdy1, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      chk("rst_res_vld", rv1, 1'b0);
      chk("rst_res", res1, 0);
      chk("rst_busy", bc1, 0);
      chk("rst_err", err1, 1'b0);
      chk("rst_arg_rdy", rdy1, 1'b1);
      chk("rst_arg_rdy_u2", rdy2, 1'b1);

      // single task, formula 1
      @(posedge clk);
      #1;
      send(1, 4, 9, 16);
      tick();
      chk("t1_busy_1", bc1, 1);
      wait_n(1, 1, 100, "t1_got_result");
      chk("t1_res", q1[0], 9);
      chk("t1_res_vld_hi", rv1, 1'b1);
      chk("t1_busy_0", bc1, 0);
      tick();
      chk("t1_pulse_end", rv1, 1'b0);
      repeat (10) tick();
      chk("t1_single_pulse", 32'(q1.size()), 1);

      // formula 2 directed, then a back-to-back random stream
      @(posedge clk);
      #1;
      send(2, 6, 5, 16);
      wait_n(2, 1, 200, "t2_got_result");
      chk("t2_res", q2[0], 3);
      for (int i = 0; i < 100; i++) begin
         ea[i] = $urandom & 32'h7fff_ffff;
         eb[i] = $urandom & 32'h7fff_ffff;
         ec[i] = $urandom;
      end
      @(posedge clk);
      #1;
      stall2 = 0;
      for (int i = 0; i < 100; i++) send(2, ea[i], eb[i], ec[i]);
      chk("t2_no_stall", 32'(stall2), 0);
      wait_n(2, 101, 400, "t2_stream_count");
      for (int i = 0; i < 100; i++) begin
         if (i + 1 < q2.size()) chk($sformatf("t2_stream_%0d", i), q2[i+1], f2m(ea[i], eb[i], ec[i]));
      end
      chk("t2_err", err2, 1'b0);

      // two channels, five tasks
      @(posedge clk);
      #1;
      send(3, 1, 4, 9);
      send(3, 100, 0, 2);
      tick();
      chk("t3_rdy_low", rdy3, 1'b0);
      chk("t3_busy_2", bc3, 2);
      @(posedge clk);
      #1;
      send(3, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff);
      send(3, 15, 24, 35);
      send(3, 65536, 1, 3);
      wait_n(3, 5, 600, "t3_count");
      repeat (80) tick();
      chk("t3_no_dup", 32'(q3.size()), 5);
      chk("t3_r0", q3[0], 6);
      chk("t3_r1", q3[1], 11);
      chk("t3_r2", q3[2], 196605);
      chk("t3_r3", q3[3], 12);
      chk("t3_r4", q3[4], 258);

      // backpressure: output held while all channels fill
      q1.delete();
      @(posedge clk);
      #1;
      rr1 = 1'b0;
      send(1, 0, 0, 0);
      send(1, 1, 2, 3);
      send(1, 25, 36, 49);
      send(1, 1000000, 99, 7);
      send(1, 2, 2, 2);
      repeat (30) tick();
      chk("t4_rdy_low", rdy1, 1'b0);
      chk("t4_busy_full", bc1, 4);
      chk("t4_vld_held", rv1, 1'b1);
      chk("t4_res_held", res1, 0);
      unstable = 0;
      repeat (40) begin
         tick();
         if (rv1 !== 1'b1 || res1 !== 32'd0) unstable++;
      end
      chk("t4_stable", 32'(unstable), 0);
      chk("t4_nothing_taken", 32'(q1.size()), 0);
      e4 = '{0, 3, 18, 1011, 3};
      @(posedge clk);
      #1;
      rr1 = 1'b1;
      wait_n(1, 5, 200, "t4_drain_count");
      for (int i = 0; i < 5; i++) begin
         if (i < q1.size()) chk($sformatf("t4_drain_%0d", i), q1[i], e4[i]);
      end

      // reset with tasks in flight
      repeat (5) tick();
      q1.delete();
      @(posedge clk);
      #1;
      send(1, 7, 7, 7);
      send(1, 8, 8, 8);
      send(1, 9, 9, 9);
      repeat (3) tick();
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      chk("t5_res_vld", rv1, 1'b0);
      chk("t5_res", res1, 0);
      chk("t5_busy", bc1, 0);
      chk("t5_err", err1, 1'b0);
      chk("t5_arg_rdy", rdy1, 1'b1);
      repeat (60) tick();
      chk("t5_no_stale", 32'(q1.size()), 0);
      @(posedge clk);
      #1;
      send(1, 1, 1, 1);
      wait_n(1, 1, 100, "t5_new_count");
      chk("t5_new_res", q1[0], 3);

      // stray worker result on an idle channel
      repeat (5) tick();
      q1.delete();
      @(posedge clk);
      #1;
      force u1.wrk_vld = 4'b0001;
      @(posedge clk);
      #1;
      release u1.wrk_vld;
      tick();
      chk("t6_err_set", err1, 1'b1);
      chk("t6_busy", bc1, 0);
      chk("t6_no_output", rv1, 1'b0);
      repeat (10) tick();
      chk("t6_err_sticky", err1, 1'b1);
      chk("t6_no_stray_emit", 32'(q1.size()), 0);
      @(posedge clk);
      #1;
      send(1, 4, 9, 16);
      wait_n(1, 1, 100, "t6_count");
      chk("t6_res", q1[0], 9);
      chk("t6_err_still", err1, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      chk("t6_err_cleared", err1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
